// File: rtl/hdlc_pkg.sv
// rtl/hdlc_pkg.sv - shared states, line patterns and CRC constants for the HDLC transmit framer
package hdlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_FLAG,
        ST_DATA,
        ST_FCS,
        ST_END_FLAG,
        ST_ABORT
    } tx_state_t;

    localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT = 8'hFE;
    localparam logic [2:0]  STUFF_RUN  = 3'd5;
    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    // The CRC shifts LSB first, so it needs the bit-reversed polynomial.
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hdlc_tx_crc16.sv
// rtl/hdlc_tx_crc16.sv - bit-serial reflected CRC-16-CCITT over unstuffed data bits
module hdlc_tx_crc16
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[0] ^ din;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = {1'b0, crc_q[15:1]} ^ (fb ? reflect16(CRC_POLY) : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// rtl/hdlc_tx_framer.sv - HDLC Tx bit framer: flags, zero insertion, abort, idle; FCS when HDLC_TX_FCS_EN
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int NUM_START_FLAGS = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Start,
    input  logic [7:0] Tx_Byte,
    input  logic       Tx_ByteValid,
    input  logic       Tx_Last,
    output logic       Tx_ByteReady,
    input  logic       Tx_AbortReq,
    output logic       Tx,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Underrun
);

    localparam logic [1:0] LAST_FLAG = 2'(NUM_START_FLAGS - 1);

    // State, counter and shift register describe the bit currently on Tx.
    tx_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  flag_num_q, flag_num_d;
    logic [15:0] shreg_q, shreg_d;
    logic [2:0]  stuff_q, stuff_d;
    logic        last_q, last_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        abrt_q, abrt_d;
    logic        undr_q, undr_d;
    logic        ready, byte_end, go_abort;
    logic [2:0]  nxt_idx;

`ifdef HDLC_TX_FCS_EN
    logic        crc_clr, crc_en, crc_din;
    logic [15:0] crc, fcs;

    hdlc_tx_crc16 u_crc (
        .clk (Clk),
        .rst (Rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (crc_din),
        .crc (crc)
    );

    assign fcs = ~crc;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flag_num_d = flag_num_q;
        shreg_d    = shreg_q;
        stuff_d    = stuff_q;
        last_d     = last_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        abrt_d     = 1'b0;
        undr_d     = 1'b0;
`ifdef HDLC_TX_FCS_EN
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_din    = 1'b0;
`endif
        nxt_idx  = cnt_q[2:0] + 3'd1;
        // A pending stuff bit holds off the end of the byte by one cycle.
        byte_end = (cnt_q == ((state_q == ST_FCS) ? 4'd15 : 4'd7)) && (stuff_q != STUFF_RUN);
        ready    = ((state_q == ST_START_FLAG) && (cnt_q == 4'd7) && (flag_num_q == LAST_FLAG))
                || ((state_q == ST_DATA) && byte_end && !last_q);
        go_abort = ((state_q == ST_START_FLAG) || (state_q == ST_DATA) || (state_q == ST_FCS))
                && (Tx_AbortReq || (ready && !Tx_ByteValid));

        if (go_abort) begin
            state_d = ST_ABORT;
            cnt_d   = 4'd0;
            stuff_d = 3'd0;
            tx_d    = HDLC_ABORT[0];
            undr_d  = ready && !Tx_ByteValid;
        end else if (ready) begin
            state_d = ST_DATA;
            cnt_d   = 4'd0;
            last_d  = Tx_Last;
            tx_d    = Tx_Byte[0];
            shreg_d = {9'd0, Tx_Byte[7:1]};
            if (!Tx_Byte[0]) begin
                stuff_d = 3'd0;
            end else if (state_q == ST_START_FLAG) begin
                stuff_d = 3'd1;
            end else begin
                stuff_d = stuff_q + 3'd1;
            end
`ifdef HDLC_TX_FCS_EN
            crc_en  = 1'b1;
            crc_din = Tx_Byte[0];
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_d = 1'b1;
                    if (Tx_Start) begin
                        state_d    = ST_START_FLAG;
                        cnt_d      = 4'd0;
                        flag_num_d = 2'd0;
                        tx_d       = HDLC_FLAG[0];
`ifdef HDLC_TX_FCS_EN
                        crc_clr    = 1'b1;
`endif
                    end
                end
                ST_START_FLAG: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d      = 4'd0;
                        flag_num_d = flag_num_q + 2'd1;
                        tx_d       = HDLC_FLAG[0];
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        tx_d  = HDLC_FLAG[nxt_idx];
                    end
                end
                ST_DATA, ST_FCS: begin
                    if (stuff_q == STUFF_RUN) begin
                        tx_d    = 1'b0;
                        stuff_d = 3'd0;
                    end else if (byte_end) begin
`ifdef HDLC_TX_FCS_EN
                        if (state_q == ST_DATA) begin
                            state_d = ST_FCS;
                            cnt_d   = 4'd0;
                            tx_d    = fcs[0];
                            shreg_d = {1'b0, fcs[15:1]};
                            stuff_d = fcs[0] ? stuff_q + 3'd1 : 3'd0;
                        end else begin
                            state_d = ST_END_FLAG;
                            cnt_d   = 4'd0;
                            stuff_d = 3'd0;
                            tx_d    = HDLC_FLAG[0];
                        end
`else
                        state_d = ST_END_FLAG;
                        cnt_d   = 4'd0;
                        stuff_d = 3'd0;
                        tx_d    = HDLC_FLAG[0];
`endif
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[15:1]};
                        stuff_d = shreg_q[0] ? stuff_q + 3'd1 : 3'd0;
`ifdef HDLC_TX_FCS_EN
                        crc_en  = (state_q == ST_DATA);
                        crc_din = shreg_q[0];
`endif
                    end
                end
                ST_END_FLAG: begin
                    done_d = (cnt_q == 4'd6);
                    if (cnt_q == 4'd7) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        tx_d  = HDLC_FLAG[nxt_idx];
                    end
                end
                ST_ABORT: begin
                    abrt_d = (cnt_q == 4'd6);
                    if (cnt_q == 4'd7) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        tx_d  = HDLC_ABORT[nxt_idx];
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            flag_num_q <= 2'd0;
            shreg_q    <= 16'd0;
            stuff_q    <= 3'd0;
            last_q     <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            abrt_q     <= 1'b0;
            undr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flag_num_q <= flag_num_d;
            shreg_q    <= shreg_d;
            stuff_q    <= stuff_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            abrt_q     <= abrt_d;
            undr_q     <= undr_d;
        end
    end

    assign Tx              = tx_q;
    assign Tx_Busy         = (state_q != ST_IDLE);
    assign Tx_ByteReady    = ready;
    assign Tx_Done         = done_q;
    assign Tx_AbortedTrans = abrt_q;
    assign Tx_Underrun     = undr_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb/tb_hdlc_tx_framer.sv - directed-vector bench for hdlc_tx_framer
module tb_hdlc_tx_framer;

    logic       Clk;
    logic       Rst;
    logic       Tx_Start;
    logic [7:0] Tx_Byte;
    logic       Tx_ByteValid;
    logic       Tx_Last;
    logic       Tx_ByteReady;
    logic       Tx_AbortReq;
    logic       Tx;
    logic       Tx_Busy;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic       Tx_Underrun;

    hdlc_tx_framer #(.NUM_START_FLAGS(1)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tx_Start        (Tx_Start),
        .Tx_Byte         (Tx_Byte),
        .Tx_ByteValid    (Tx_ByteValid),
        .Tx_Last         (Tx_Last),
        .Tx_ByteReady    (Tx_ByteReady),
        .Tx_AbortReq     (Tx_AbortReq),
        .Tx              (Tx),
        .Tx_Busy         (Tx_Busy),
        .Tx_Done         (Tx_Done),
        .Tx_AbortedTrans (Tx_AbortedTrans),
        .Tx_Underrun     (Tx_Underrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int    vec_cnt = 0;
    int    err_cnt = 0;
    string flag_s  = "01111110";
    string abort_s = "01111111";
    logic [7:0] fb [0:3];
    int    fn;
    string cap_s;
    int    done_pos, abt_pos, und_pos, rdy_cnt;

    // Runs one frame, recording every Tx bit from the first flag bit until Tx_Done or Tx_AbortedTrans.
    task automatic run_frame(input int abort_at, input int withhold, input int max_cyc);
        int  idx;
        int  pos;
        logic take;
        idx = 0;
        cap_s = "";
        done_pos = -1; abt_pos = -1; und_pos = -1; rdy_cnt = 0;
        Tx_Byte = fb[0];
        Tx_Last = (fn == 1);
        Tx_ByteValid = (withhold != 0);
        Tx_Start = 1'b1;
        @(posedge Clk); #1;
        Tx_Start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            Tx_AbortReq = (cap_s.len() == abort_at);
            @(negedge Clk);
            take = Tx_ByteReady && Tx_ByteValid;
            if (Tx_ByteReady) rdy_cnt++;
            pos = cap_s.len();
            cap_s = {cap_s, (Tx === 1'b1) ? "1" : "0"};
            if (Tx_Done) done_pos = pos;
            if (Tx_AbortedTrans) abt_pos = pos;
            if (Tx_Underrun) und_pos = pos;
            @(posedge Clk); #1;
            if (take) begin
                idx++;
                if (idx < fn) begin
                    Tx_Byte = fb[idx];
                    Tx_Last = (idx == fn - 1);
                    Tx_ByteValid = (idx != withhold);
                end else begin
                    Tx_ByteValid = 1'b0;
                end
            end
            if (done_pos >= 0 || abt_pos >= 0) break;
        end
        Tx_AbortReq = 1'b0;
        Tx_ByteValid = 1'b0;
        Tx_Last = 1'b0;
    endtask

    task automatic test_reset;
        vec_cnt++; if (Tx !== 1'b1) begin err_cnt++; $display("FAIL reset_tx: got %b exp 1", Tx); end
        vec_cnt++; if (Tx_Busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b exp 0", Tx_Busy); end
        vec_cnt++; if (Tx_ByteReady !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b exp 0", Tx_ByteReady); end
        vec_cnt++; if (Tx_Done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b exp 0", Tx_Done); end
        vec_cnt++; if (Tx_AbortedTrans !== 1'b0) begin err_cnt++; $display("FAIL reset_aborted: got %b exp 0", Tx_AbortedTrans); end
        vec_cnt++; if (Tx_Underrun !== 1'b0) begin err_cnt++; $display("FAIL reset_underrun: got %b exp 0", Tx_Underrun); end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 32; i++) begin
            @(negedge Clk);
            vec_cnt++;
            if (Tx !== 1'b1 || Tx_Busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL idle_line cycle %0d: got tx=%b busy=%b exp tx=1 busy=0", i, Tx, Tx_Busy);
            end
        end
    endtask

    task automatic test_frame(input string name, input string exp, input int exp_rdy);
        run_frame(-1, -1, 200);
        vec_cnt++; if (cap_s != exp) begin err_cnt++; $display("FAIL %s_bits: got %s exp %s", name, cap_s, exp); end
        vec_cnt++; if (done_pos != exp.len() - 1) begin err_cnt++; $display("FAIL %s_done: got %0d exp %0d", name, done_pos, exp.len() - 1); end
        vec_cnt++; if (rdy_cnt != exp_rdy) begin err_cnt++; $display("FAIL %s_ready: got %0d exp %0d", name, rdy_cnt, exp_rdy); end
        vec_cnt++; if (abt_pos != -1) begin err_cnt++; $display("FAIL %s_noabort: got %0d exp -1", name, abt_pos); end
        @(negedge Clk);
        vec_cnt++; if (Tx !== 1'b1 || Tx_Busy !== 1'b0) begin err_cnt++; $display("FAIL %s_after: got tx=%b busy=%b exp 1 0", name, Tx, Tx_Busy); end
    endtask

    task automatic test_single_byte;
        fb[0] = 8'h55; fn = 1;
        test_frame("byte55", {flag_s, "10101010", flag_s}, 1);
    endtask

    task automatic test_stuffing;
        fb[0] = 8'h7E; fn = 1;
        test_frame("data7e", {flag_s, "011111010", flag_s}, 1);
        fb[0] = 8'hFF; fb[1] = 8'hFF; fn = 2;
        test_frame("dataff", {flag_s, "1111101111101111101", flag_s}, 2);
        fb[0] = 8'hF8; fb[1] = 8'h01; fn = 2;
        test_frame("delayreq", {flag_s, "000111110", "10000000", flag_s}, 2);
        fb[0] = 8'hF8; fn = 1;
        test_frame("trailstuff", {flag_s, "000111110", flag_s}, 1);
    endtask

    task automatic test_abort;
        fb[0] = 8'hA5; fn = 1;
        run_frame(10, -1, 200);
        vec_cnt++; if (cap_s != {flag_s, "101", abort_s}) begin err_cnt++; $display("FAIL abort_bits: got %s exp %s", cap_s, {flag_s, "101", abort_s}); end
        vec_cnt++; if (abt_pos != 18) begin err_cnt++; $display("FAIL abort_pulse: got %0d exp 18", abt_pos); end
        vec_cnt++; if (done_pos != -1) begin err_cnt++; $display("FAIL abort_nodone: got %0d exp -1", done_pos); end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            vec_cnt++;
            if (Tx !== 1'b1 || Tx_Busy !== 1'b0 || Tx_Done !== 1'b0) begin
                err_cnt++;
                $display("FAIL abort_after: got tx=%b busy=%b done=%b exp 1 0 0", Tx, Tx_Busy, Tx_Done);
            end
        end
    endtask

    task automatic test_underrun;
        fb[0] = 8'h55; fb[1] = 8'h33; fn = 2;
        run_frame(-1, 1, 200);
        vec_cnt++; if (cap_s != {flag_s, "10101010", abort_s}) begin err_cnt++; $display("FAIL underrun_bits: got %s exp %s", cap_s, {flag_s, "10101010", abort_s}); end
        vec_cnt++; if (und_pos != 16) begin err_cnt++; $display("FAIL underrun_pulse: got %0d exp 16", und_pos); end
        vec_cnt++; if (abt_pos != 23) begin err_cnt++; $display("FAIL underrun_aborted: got %0d exp 23", abt_pos); end
        vec_cnt++; if (done_pos != -1) begin err_cnt++; $display("FAIL underrun_nodone: got %0d exp -1", done_pos); end
        @(negedge Clk);
    endtask

    task automatic test_reset_mid(input string exp01);
        Tx_Byte = 8'hFF; Tx_Last = 1'b0; Tx_ByteValid = 1'b1; Tx_Start = 1'b1;
        @(posedge Clk); #1;
        Tx_Start = 1'b0;
        repeat (12) @(posedge Clk);
        @(negedge Clk);
        vec_cnt++; if (Tx_Busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before: got %b exp 1", Tx_Busy); end
        #2 Rst = 1'b1;
        #1;
        vec_cnt++; if (Tx !== 1'b1) begin err_cnt++; $display("FAIL midrst_tx: got %b exp 1", Tx); end
        vec_cnt++; if (Tx_Busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b exp 0", Tx_Busy); end
        Tx_ByteValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        fb[0] = 8'h01; fn = 1;
        test_frame("after_rst01", exp01, 1);
    endtask

    initial begin
        Rst = 1'b0; Tx_Start = 1'b0; Tx_Byte = 8'h00; Tx_ByteValid = 1'b0;
        Tx_Last = 1'b0; Tx_AbortReq = 1'b0;
        #1 Rst = 1'b1;
        #1 test_reset();
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        test_idle();
`ifdef HDLC_TX_FCS_EN
        test_abort();
        test_underrun();
        test_reset_mid({flag_s, "10000000", "10001111100000111", flag_s});
`else
        test_single_byte();
        test_stuffing();
        test_abort();
        test_underrun();
        test_reset_mid({flag_s, "10000000", flag_s});
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Bit-level HDLC transmit channel. Takes bytes from the Tx buffer over a valid/ready handshake and emits a serial Tx stream with these elements:
- opening flag(s) and closing flag;
- zero insertion after five consecutive 1s;
- optional FCS;
- abort pattern;
- idle 1s.

It is the transmit-side counterpart of the Rx flag/abort/zero-removal channel.

Parameters:
NUM_START_FLAGS, 1, number of opening flags (0x7E) sent before data; legal range 1..4.

Ports:
Clk  input  1  system clock
Rst  input  1  asynchronous reset, active-high
Tx_Start  input  1  frame request; sampled only in IDLE
Tx_Byte  input  8  data byte, transmitted LSB first
Tx_ByteValid  input  1  Tx_Byte valid
Tx_Last  input  1  qualifies Tx_Byte as final byte of the frame
Tx_ByteReady  output  1  framer takes Tx_Byte this cycle (combinational)
Tx_AbortReq  input  1  abort current frame
Tx  output  1  serial line, registered
Tx_Busy  output  1  frame in progress
Tx_Done  output  1  1-cycle pulse, frame completed
Tx_AbortedTrans  output  1  1-cycle pulse, abort pattern completed
Tx_Underrun  output  1  1-cycle pulse, byte not available when needed

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; Tx=1; Tx_Busy=0; all pulses=0; stuff counter=0; shift register=0.
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- IDLE:
  - Tx=1 continuously.
  - Tx_Start=1 → START_FLAG; first flag bit (0) appears on Tx the next cycle.
- START_FLAG:
  - Sends NUM_START_FLAGS x 01111110, unstuffed.
  - Tx_ByteReady is high during the final flag bit; transfer occurs when Tx_ByteReady && Tx_ByteValid.
  - No transfer → Tx_Underrun, enter ABORT.
- DATA:
  - Shifts byte LSB first.
  - Stuff counter counts consecutive output 1s, clears on any 0. When count=5, the next output bit is an inserted 0, the shift register holds, and the counter clears.
  - Counter clears on entering DATA; flags never count.
  - Next byte is requested (Tx_ByteReady) on the cycle the last bit of the current byte is driven, provided no stuff bit is pending. A pending stuff bit delays the request by one cycle.
  - After a byte with Tx_Last=1 → FCS (with FCS_EN) or END_FLAG. Any stuff 0 owed to its trailing 1s is inserted first.
  - Missing byte when requested (not last) → Tx_Underrun pulse, enter ABORT.
- END_FLAG:
  - Sends 01111110, unstuffed.
  - Tx_Done pulses in the cycle the final 0 is driven; then IDLE.
  - Tx_AbortReq is ignored here.
- ABORT:
  - Entered from START_FLAG/DATA/FCS on Tx_AbortReq=1 or on underrun. The in-flight byte is discarded.
  - Next Tx bit is 0, followed by seven 1s, unstuffed.
  - Tx_AbortedTrans pulses with the 7th 1; then IDLE. Tx stays 1.
- Tx_Busy=1 from the first flag bit through the last bit of END_FLAG/ABORT.
- Tx_Start while Tx_Busy=1 is ignored.
- Tx_AbortReq and underrun in the same cycle: one abort sequence, both pulses.

Optional Feature:
Macro HDLC_TX_FCS_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, reflected, init 0xFFFF) runs over all data bits before stuffing.
  - FCS state sends the ones-complement CRC, 16 bits LSB first, stuffed; then END_FLAG.
  - Abort during FCS is honoured.
- Undefined: no CRC logic; the last data byte goes directly to END_FLAG.

Decomposition:
- Package hdlc_pkg:
  - tx_state_t enum;
  - HDLC_FLAG=8'h7E;
  - HDLC_ABORT=8'hFE (LSB-first 0 then seven 1s);
  - STUFF_RUN=5;
  - CRC_POLY=16'h1021;
  - CRC_INIT=16'hFFFF.
- Sub-module hdlc_tx_crc16 (bit-serial update, clear, enable), instantiated only under HDLC_TX_FCS_EN.

Test Plan:
- Idle: no Tx_Start for 32 cycles after reset → Tx=1 every cycle; Tx_Busy=0.
- Single byte 0x55, Tx_Last=1, FCS off → Tx 01111110, 10101010, 01111110; Tx_Done on final 0; Tx_ByteReady high once.
- Byte 0x7E as data → Tx data bits 0,1,1,1,1,1,0,1,0 (stuff 0 after 5th 1). Bytes 0xFF,0xFF → a 0 is inserted after every five 1s; no run longer than 5.
- Tx_AbortReq at 3rd data bit of byte 0xA5 → next 8 Tx bits 0,1,1,1,1,1,1,1. Tx_AbortedTrans pulses on 8th bit; Tx=1 after; Tx_Done never asserts.
- Underrun: 2-byte frame with Tx_ByteValid low when 2nd byte is requested → Tx_Underrun and Tx_AbortedTrans pulse; abort pattern on Tx.
- Rst asserted mid-DATA → Tx=1 and Tx_Busy=0 immediately (asynchronous, not waiting for Clk). After release, a new frame of 0x01 is sent correctly.
- HDLC_TX_FCS_EN: frame 0x01 → FCS bits on Tx match the reference CRC-16-CCITT of 0x01, complemented, LSB first, stuffed. Looped to the Rx channel → no Rx_FCSerr.
